// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control FSM for the single-issue RISC-V core. It walks each
// instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WRITE. It emits
// one-cycle stage strobes and handshakes with variable-latency instruction
// and data memories. The program stops when the PC written back equals
// FINAL_PC, or when a memory request waits too long for its acknowledge.
//
// Ports:
//   CLK, RSTN           clock (rising edge), asynchronous active-low reset
//   START               one-cycle pulse, accepted only in S_IDLE / S_HALT
//   FINAL_PC, PC        end-of-program PC and the datapath PC
//   IS_MEM              current instruction is a load/store (valid in S_EXEC)
//   IMEM_REQ/IMEM_ACK   instruction memory handshake
//   DMEM_REQ/DMEM_ACK   data memory handshake
//   FETCH_EN, DECODE_EN, EXEC_EN, WRITE_EN   stage strobes (combinational)
//   BUSY                sequencer is running an instruction (registered)
//   COMPLETED, ERROR    program reached FINAL_PC / memory timed out
//   CYCLE_CNT           saturating count of busy cycles
//   RETIRED_CNT         saturating count of written-back instructions
// -----------------------------------------------------------------------------
module cpu_sequencer #(
   parameter int PC_W    = 32,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             START,
   input  logic [PC_W-1:0]  FINAL_PC,
   input  logic [PC_W-1:0]  PC,
   input  logic             IS_MEM,
   output logic             IMEM_REQ,
   input  logic             IMEM_ACK,
   output logic             DMEM_REQ,
   input  logic             DMEM_ACK,
   output logic             FETCH_EN,
   output logic             DECODE_EN,
   output logic             EXEC_EN,
   output logic             WRITE_EN,
   output logic             BUSY,
   output logic             COMPLETED,
   output logic             ERROR,
   output logic [CNT_W-1:0] CYCLE_CNT,
   output logic [CNT_W-1:0] RETIRED_CNT
);

   // The wait counter only ever has to reach TIMEOUT-1.
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WRITE,
      S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               completed_q, completed_d;
   logic               error_q, error_d;
   logic [CNT_W-1:0]   cycle_q, cycle_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               expire;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Expiry only matters on a cycle where the ACK is low; an ACK on the
   // same cycle is handled first and wins.
   assign expire = (TIMEOUT > 0) && (wait_q == WAIT_LAST);

   always_comb begin
      state_d     = state_q;
      completed_d = completed_q;
      error_d     = error_q;
      cycle_d     = cycle_q;
      retired_d   = retired_q;
      wait_d      = wait_q;
      IMEM_REQ    = 1'b0;
      DMEM_REQ    = 1'b0;
      FETCH_EN    = 1'b0;
      DECODE_EN   = 1'b0;
      EXEC_EN     = 1'b0;
      WRITE_EN    = 1'b0;

      if (busy_q) begin
         cycle_d = sat_inc(cycle_q);
      end

      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            IMEM_REQ = 1'b1;
            if (IMEM_ACK) begin
               FETCH_EN = 1'b1;
               state_d  = S_DECODE;
            end else if (expire) begin
               error_d = 1'b1;
               state_d = S_HALT;
            end else if (TIMEOUT > 0) begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            DECODE_EN = 1'b1;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            EXEC_EN = 1'b1;
            if (IS_MEM) begin
               state_d = S_MEM;
               wait_d  = '0;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_MEM: begin
            DMEM_REQ = 1'b1;
            if (DMEM_ACK) begin
               state_d = S_WRITE;
            end else if (expire) begin
               error_d = 1'b1;
               state_d = S_HALT;
            end else if (TIMEOUT > 0) begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WRITE: begin
            WRITE_EN  = 1'b1;
            retired_d = sat_inc(retired_q);
            if (PC == FINAL_PC) begin
               completed_d = 1'b1;
               state_d     = S_HALT;
            end else begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_HALT: begin
            // Counters are frozen here; a new START begins a fresh run.
            if (START) begin
               state_d     = S_FETCH;
               wait_d      = '0;
               completed_d = 1'b0;
               error_d     = 1'b0;
               cycle_d     = '0;
               retired_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         completed_q <= 1'b0;
         error_q     <= 1'b0;
         cycle_q     <= '0;
         retired_q   <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         completed_q <= completed_d;
         error_q     <= error_d;
         cycle_q     <= cycle_d;
         retired_q   <= retired_d;
         wait_q      <= wait_d;
      end
   end

   assign BUSY        = busy_q;
   assign COMPLETED   = completed_q;
   assign ERROR       = error_q;
   assign CYCLE_CNT   = cycle_q;
   assign RETIRED_CNT = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Self-checking bench for cpu_sequencer (TIMEOUT=4). Memory acknowledges are
// scheduled by the bench per instruction. Expected strobes per cycle and the
// expected counter totals come from the instruction-level timing rules:
// fetch takes wait+1 cycles, decode 1, exec 1, mem wait+1 (load/store only),
// and write 1.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

   localparam int PC_W    = 32;
   localparam int CNT_W   = 32;
   localparam int TIMEOUT = 4;

   logic             CLK = 1'b0;
   logic             RSTN = 1'b0;
   logic             START = 1'b0;
   logic [PC_W-1:0]  FINAL_PC = '0;
   logic [PC_W-1:0]  PC = '0;
   logic             IS_MEM = 1'b0;
   logic             IMEM_REQ;
   logic             IMEM_ACK = 1'b0;
   logic             DMEM_REQ;
   logic             DMEM_ACK = 1'b0;
   logic             FETCH_EN, DECODE_EN, EXEC_EN, WRITE_EN;
   logic             BUSY, COMPLETED, ERROR;
   logic [CNT_W-1:0] CYCLE_CNT, RETIRED_CNT;

   int errors = 0;
   int checks = 0;

   // {IMEM_REQ, DMEM_REQ, FETCH_EN, DECODE_EN, EXEC_EN, WRITE_EN}
   logic [5:0] strb;
   assign strb = {IMEM_REQ, DMEM_REQ, FETCH_EN, DECODE_EN, EXEC_EN, WRITE_EN};

   cpu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RSTN(RSTN), .START(START), .FINAL_PC(FINAL_PC), .PC(PC),
      .IS_MEM(IS_MEM), .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK),
      .DMEM_REQ(DMEM_REQ), .DMEM_ACK(DMEM_ACK), .FETCH_EN(FETCH_EN),
      .DECODE_EN(DECODE_EN), .EXEC_EN(EXEC_EN), .WRITE_EN(WRITE_EN),
      .BUSY(BUSY), .COMPLETED(COMPLETED), .ERROR(ERROR),
      .CYCLE_CNT(CYCLE_CNT), .RETIRED_CNT(RETIRED_CNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic do_reset();
      @(negedge CLK);
      RSTN = 1'b0;
      START = 1'b0; IMEM_ACK = 1'b0; DMEM_ACK = 1'b0; IS_MEM = 1'b0;
      @(negedge CLK);
      RSTN = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   // Runs one instruction starting in the fetch state: IMEM_ACK after di low
   // cycles, optional memory stage with DMEM_ACK after dm low cycles.
   task automatic run_instr(input int di, input bit mem, input int dm, input bit last);
      logic [5:0] exp;
      for (int k = 0; k <= di; k++) begin
         IMEM_ACK = (k == di);
         @(negedge CLK);
         exp = {1'b1, 1'b0, (k == di), 3'b000};
         checks++;
         if (strb !== exp) begin
            errors++;
            $display("FAIL fetch_strobes k=%0d got=%b want=%b", k, strb, exp);
         end
         @(posedge CLK); #1;
      end
      IMEM_ACK = 1'b0;
      @(negedge CLK);
      checks++;
      if (strb !== 6'b000100) begin
         errors++;
         $display("FAIL decode_strobes got=%b want=000100", strb);
      end
      @(posedge CLK); #1;
      IS_MEM = mem;
      @(negedge CLK);
      checks++;
      if (strb !== 6'b000010) begin
         errors++;
         $display("FAIL exec_strobes got=%b want=000010", strb);
      end
      @(posedge CLK); #1;
      IS_MEM = 1'b0;
      if (mem) begin
         for (int k = 0; k <= dm; k++) begin
            DMEM_ACK = (k == dm);
            @(negedge CLK);
            checks++;
            if (strb !== 6'b010000) begin
               errors++;
               $display("FAIL mem_strobes k=%0d got=%b want=010000", k, strb);
            end
            @(posedge CLK); #1;
         end
         DMEM_ACK = 1'b0;
      end
      PC = last ? FINAL_PC : (FINAL_PC ^ 32'h4);
      @(negedge CLK);
      checks++;
      if (strb !== 6'b000001 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL write_strobes got=%b busy=%b want=000001 busy=1", strb, BUSY);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      #12;
      checks++;
      if ({strb, BUSY, COMPLETED, ERROR} !== 9'b0 || CYCLE_CNT !== '0 || RETIRED_CNT !== '0) begin
         errors++;
         $display("FAIL reset_outputs got strb=%b busy=%b cmp=%b err=%b cyc=%0d ret=%0d want all 0",
                  strb, BUSY, COMPLETED, ERROR, CYCLE_CNT, RETIRED_CNT);
      end
      @(negedge CLK);
      RSTN = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_basic();
      logic [5:0] exp;
      do_reset();
      FINAL_PC = 32'd100; PC = 32'd0; IMEM_ACK = 1'b1;
      pulse_start();
      for (int c = 1; c <= 12; c++) begin
         @(negedge CLK);
         case ((c - 1) % 4)
            0: exp = 6'b101000;
            1: exp = 6'b000100;
            2: exp = 6'b000010;
            default: exp = 6'b000001;
         endcase
         checks++;
         if (strb !== exp) begin
            errors++;
            $display("FAIL basic_strobes cycle=%0d got=%b want=%b", c, strb, exp);
         end
         @(posedge CLK); #1;
      end
      IMEM_ACK = 1'b0;
      checks++;
      if (CYCLE_CNT !== 32'd12 || RETIRED_CNT !== 32'd3) begin
         errors++;
         $display("FAIL basic_counters got cyc=%0d ret=%0d want cyc=12 ret=3", CYCLE_CNT, RETIRED_CNT);
      end
   endtask

   task automatic test_mem();
      do_reset();
      FINAL_PC = 32'd200;
      pulse_start();
      run_instr(0, 1'b1, 3, 1'b0);
      checks++;
      if (CYCLE_CNT !== 32'd8 || RETIRED_CNT !== 32'd1 || IMEM_REQ !== 1'b1) begin
         errors++;
         $display("FAIL mem_instr got cyc=%0d ret=%0d ireq=%b want cyc=8 ret=1 ireq=1",
                  CYCLE_CNT, RETIRED_CNT, IMEM_REQ);
      end
   endtask

   task automatic test_complete();
      do_reset();
      FINAL_PC = 32'd35;
      pulse_start();
      run_instr(0, 1'b0, 0, 1'b0);
      run_instr(1, 1'b1, 0, 1'b1);
      checks++;
      if (COMPLETED !== 1'b1 || BUSY !== 1'b0 || ERROR !== 1'b0 ||
          CYCLE_CNT !== 32'd10 || RETIRED_CNT !== 32'd2) begin
         errors++;
         $display("FAIL complete_state got cmp=%b busy=%b err=%b cyc=%0d ret=%0d want 1 0 0 10 2",
                  COMPLETED, BUSY, ERROR, CYCLE_CNT, RETIRED_CNT);
      end
      for (int c = 0; c < 10; c++) begin
         IMEM_ACK = 1'($urandom); DMEM_ACK = 1'($urandom);
         @(negedge CLK);
         checks++;
         if (strb !== 6'b0 || CYCLE_CNT !== 32'd10 || RETIRED_CNT !== 32'd2 || COMPLETED !== 1'b1) begin
            errors++;
            $display("FAIL halt_frozen c=%0d got strb=%b cyc=%0d ret=%0d cmp=%b", c, strb,
                     CYCLE_CNT, RETIRED_CNT, COMPLETED);
         end
         @(posedge CLK); #1;
      end
      IMEM_ACK = 1'b0; DMEM_ACK = 1'b0;
      pulse_start();
      checks++;
      if (CYCLE_CNT !== '0 || RETIRED_CNT !== '0 || COMPLETED !== 1'b0 || IMEM_REQ !== 1'b1) begin
         errors++;
         $display("FAIL restart_clear got cyc=%0d ret=%0d cmp=%b ireq=%b want 0 0 0 1",
                  CYCLE_CNT, RETIRED_CNT, COMPLETED, IMEM_REQ);
      end
      run_instr(0, 1'b0, 0, 1'b1);
      checks++;
      if (CYCLE_CNT !== 32'd4 || RETIRED_CNT !== 32'd1 || COMPLETED !== 1'b1) begin
         errors++;
         $display("FAIL restart_run got cyc=%0d ret=%0d cmp=%b want 4 1 1", CYCLE_CNT, RETIRED_CNT, COMPLETED);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      FINAL_PC = 32'd64;
      pulse_start();
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         checks++;
         if (strb !== 6'b100000) begin
            errors++;
            $display("FAIL ifetch_wait c=%0d got=%b want=100000", c, strb);
         end
         @(posedge CLK); #1;
      end
      @(negedge CLK);
      checks++;
      if (ERROR !== 1'b1 || COMPLETED !== 1'b0 || BUSY !== 1'b0 || strb !== 6'b0 || CYCLE_CNT !== 32'd4) begin
         errors++;
         $display("FAIL ifetch_timeout got err=%b cmp=%b busy=%b strb=%b cyc=%0d want 1 0 0 0 4",
                  ERROR, COMPLETED, BUSY, strb, CYCLE_CNT);
      end
      @(posedge CLK); #1;
      pulse_start();
      checks++;
      if (ERROR !== 1'b0) begin
         errors++;
         $display("FAIL error_clear got=%b want=0", ERROR);
      end
      run_instr(3, 1'b1, 3, 1'b1);
      checks++;
      if (ERROR !== 1'b0 || COMPLETED !== 1'b1 || CYCLE_CNT !== 32'd11) begin
         errors++;
         $display("FAIL ack_at_expiry got err=%b cmp=%b cyc=%0d want 0 1 11", ERROR, COMPLETED, CYCLE_CNT);
      end
      // Data memory never answers.
      pulse_start();
      IMEM_ACK = 1'b1;
      @(posedge CLK); #1;
      IMEM_ACK = 1'b0;
      @(posedge CLK); #1;
      IS_MEM = 1'b1;
      @(posedge CLK); #1;
      IS_MEM = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         checks++;
         if (strb !== 6'b010000) begin
            errors++;
            $display("FAIL dmem_wait c=%0d got=%b want=010000", c, strb);
         end
         @(posedge CLK); #1;
      end
      checks++;
      if (ERROR !== 1'b1 || COMPLETED !== 1'b0 || BUSY !== 1'b0 || RETIRED_CNT !== '0) begin
         errors++;
         $display("FAIL dmem_timeout got err=%b cmp=%b busy=%b ret=%0d want 1 0 0 0",
                  ERROR, COMPLETED, BUSY, RETIRED_CNT);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      FINAL_PC = 32'd500;
      pulse_start();
      run_instr(0, 1'b0, 0, 1'b0);
      IMEM_ACK = 1'b1;
      @(posedge CLK); #1;
      IMEM_ACK = 1'b0;
      @(posedge CLK); #1;
      IS_MEM = 1'b1;
      @(posedge CLK); #1;
      IS_MEM = 1'b0;
      checks++;
      if (DMEM_REQ !== 1'b1 || CYCLE_CNT !== 32'd7) begin
         errors++;
         $display("FAIL pre_reset_mem got dreq=%b cyc=%0d want 1 7", DMEM_REQ, CYCLE_CNT);
      end
      #2;
      RSTN = 1'b0;
      #1;
      checks++;
      if (DMEM_REQ !== 1'b0 || BUSY !== 1'b0 || CYCLE_CNT !== '0 || RETIRED_CNT !== '0 || strb !== 6'b0) begin
         errors++;
         $display("FAIL async_reset got dreq=%b busy=%b cyc=%0d ret=%0d strb=%b want all 0",
                  DMEM_REQ, BUSY, CYCLE_CNT, RETIRED_CNT, strb);
      end
      @(negedge CLK);
      RSTN = 1'b1;
      @(posedge CLK); #1;
      DMEM_ACK = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         checks++;
         if (strb !== 6'b0 || BUSY !== 1'b0 || CYCLE_CNT !== '0) begin
            errors++;
            $display("FAIL idle_after_reset c=%0d got strb=%b busy=%b cyc=%0d want 0 0 0",
                     c, strb, BUSY, CYCLE_CNT);
         end
         @(posedge CLK); #1;
         DMEM_ACK = 1'b0;
      end
   endtask

   task automatic test_ignore();
      do_reset();
      FINAL_PC = 32'd700; PC = 32'd0;
      pulse_start();
      IMEM_ACK = 1'b1;
      @(negedge CLK);
      checks++;
      if (strb !== 6'b101000) begin
         errors++;
         $display("FAIL ign_fetch got=%b want=101000", strb);
      end
      @(posedge CLK); #1;
      // Stray ACK while decoding.
      @(negedge CLK);
      checks++;
      if (strb !== 6'b000100) begin
         errors++;
         $display("FAIL ign_decode got=%b want=000100", strb);
      end
      @(posedge CLK); #1;
      IMEM_ACK = 1'b0;
      START = 1'b1;
      @(negedge CLK);
      checks++;
      if (strb !== 6'b000010) begin
         errors++;
         $display("FAIL ign_exec got=%b want=000010", strb);
      end
      @(posedge CLK); #1;
      START = 1'b0;
      @(negedge CLK);
      checks++;
      if (strb !== 6'b000001) begin
         errors++;
         $display("FAIL ign_write got=%b want=000001", strb);
      end
      @(posedge CLK); #1;
      @(negedge CLK);
      checks++;
      if (strb !== 6'b100000 || RETIRED_CNT !== 32'd1 || CYCLE_CNT !== 32'd4) begin
         errors++;
         $display("FAIL ign_next got strb=%b ret=%0d cyc=%0d want 100000 1 4", strb, RETIRED_CNT, CYCLE_CNT);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_back_to_back();
      int n, di, dm, exp_cyc;
      bit mem;
      do_reset();
      for (int p = 0; p < 5; p++) begin
         FINAL_PC = $urandom;
         n = $urandom_range(1, 5);
         exp_cyc = 0;
         pulse_start();
         for (int i = 0; i < n; i++) begin
            di  = $urandom_range(0, TIMEOUT - 1);
            dm  = $urandom_range(0, TIMEOUT - 1);
            mem = 1'($urandom);
            exp_cyc += (di + 1) + 1 + 1 + (mem ? dm + 1 : 0) + 1;
            run_instr(di, mem, dm, (i == n - 1));
         end
         checks++;
         if (COMPLETED !== 1'b1 || ERROR !== 1'b0 || BUSY !== 1'b0 ||
             CYCLE_CNT !== CNT_W'(exp_cyc) || RETIRED_CNT !== CNT_W'(n)) begin
            errors++;
            $display("FAIL program%0d got cmp=%b err=%b busy=%b cyc=%0d ret=%0d want 1 0 0 %0d %0d",
                     p, COMPLETED, ERROR, BUSY, CYCLE_CNT, RETIRED_CNT, exp_cyc, n);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mem();
      test_complete();
      test_timeout();
      test_reset_mid();
      test_ignore();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
